// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// 1 or 2 stop bits, with a per-frame baud divisor latched at accept.
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     div,
  input  logic                 s_valid,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 s_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 done
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || DIV_W < 1) begin : g_param_check
    $error("uart_tx_frame: illegal parameter value");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state, state_d;
  logic [DIV_W-1:0]     cnt, cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [DATA_BITS-1:0] sh, sh_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 done_q, done_d;
  logic                 term;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ^d : ~^d;
  endfunction

  function automatic logic [DIV_W-1:0] div_clamp(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

  assign term    = (cnt == div_q - DIV_W'(1));
  assign s_ready = (state == S_IDLE) & ~rst;
  assign busy    = (state != S_IDLE);
  assign txd     = txd_q;
  assign done    = done_q;

  // Control: state, bit/index counters, line and done registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      txd_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      idx    <= idx_d;
      txd_q  <= txd_d;
      done_q <= done_d;
    end
  end

  // Datapath: shift register, parity and divisor, loaded at accept
  always_ff @(posedge clk) begin
    sh    <= sh_d;
    par_q <= par_d;
    div_q <= div_d;
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    sh_d    = sh;
    par_d   = par_q;
    div_d   = div_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    case (state)
      S_IDLE: begin
        txd_d = 1'b1;
        if (s_valid) begin
          sh_d    = s_data;
          par_d   = parity_of(s_data);
          div_d   = div_clamp(div);
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (term) begin
          cnt_d   = '0;
          state_d = S_DATA;
          txd_d   = sh[0];
        end else begin
          cnt_d = cnt + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (term) begin
          cnt_d = '0;
          if (idx == IDX_W'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            idx_d = idx + IDX_W'(1);
            sh_d  = sh >> 1;
            txd_d = sh[1];
          end
        end else begin
          cnt_d = cnt + DIV_W'(1);
        end
      end
      S_PAR: begin
        if (term) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          cnt_d = cnt + DIV_W'(1);
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (term) begin
          cnt_d = '0;
          // idx counts stop bits here; the last one closes the frame
          if (idx == IDX_W'(STOP_BITS - 1)) begin
            idx_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt + DIV_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: 8N1, 7E1 and 8O2 instances share clock and reset.
module tb_uart_tx_frame;

  logic        clk;
  logic        rst;
  logic [15:0] dv [3];
  logic [2:0]  s_valid;
  logic [2:0]  s_ready;
  logic [2:0]  txd;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [7:0]  d0;
  logic [6:0]  d1;
  logic [7:0]  d2;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] cap;
  int nbusy, ndone, done_first, done_last;

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16)) u_8n1 (
    .clk(clk), .rst(rst), .div(dv[0]), .s_valid(s_valid[0]), .s_data(d0),
    .s_ready(s_ready[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0]));

  uart_tx_frame #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .DIV_W(16)) u_7e1 (
    .clk(clk), .rst(rst), .div(dv[1]), .s_valid(s_valid[1]), .s_data(d1),
    .s_ready(s_ready[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .DIV_W(16)) u_8o2 (
    .clk(clk), .rst(rst), .div(dv[2]), .s_valid(s_valid[2]), .s_data(d2),
    .s_ready(s_ready[2]), .txd(txd[2]), .busy(busy[2]), .done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line: all ones, with frame bits (bit 0 = start bit) each held
  // dvw cycles starting at cycle offset off.
  function automatic logic [127:0] wave(input logic [15:0] bits, input int nb,
                                        input int dvw, input int off);
    logic [127:0] e;
    e = '1;
    for (int k = 0; k < nb * dvw; k++) e[off + k] = bits[k / dvw];
    return e;
  endfunction

  task automatic set_data(input int i, input logic [7:0] w);
    case (i)
      0: d0 = w;
      1: d1 = w[6:0];
      default: d2 = w;
    endcase
  endtask

  // Presents w1 with divisor dv0, then samples len cycles starting with the
  // first start-bit cycle. s_data switches to w2 right after the accept;
  // div switches to dv1 at cycle chg_k; s_valid drops at cycle drop_k.
  task automatic run(input int i, input logic [7:0] w1, input logic [7:0] w2,
                     input logic [15:0] dv0, input int chg_k, input logic [15:0] dv1,
                     input int drop_k, input int len);
    cap = '1; nbusy = 0; ndone = 0; done_first = -1; done_last = -1;
    @(negedge clk);
    check($sformatf("ready_before_accept[%0d]", i), 128'(s_ready[i]), 128'(1));
    s_valid[i] = 1'b1;
    set_data(i, w1);
    dv[i] = dv0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      cap[k] = txd[i];
      nbusy += int'(busy[i]);
      if (done[i]) begin
        ndone++;
        if (done_first < 0) done_first = k;
        done_last = k;
      end
      if (k == 0) set_data(i, w2);
      if (k == chg_k) dv[i] = dv1;
      if (k == drop_k) s_valid[i] = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    s_valid = '0;
    d0 = '0; d1 = '0; d2 = '0;
    for (int i = 0; i < 3; i++) dv[i] = 16'd1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_txd",   128'(txd),     128'(3'b111));
    check("rst_busy",  128'(busy),    128'(3'b000));
    check("rst_done",  128'(done),    128'(3'b000));
    check("rst_ready", 128'(s_ready), 128'(3'b000));
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 128'(s_ready), 128'(3'b111));

    // 8N1 div=4, 0x55
    run(0, 8'h55, 8'h55, 16'd4, -1, 16'd0, 0, 43);
    check("t1_wave",  cap, wave(16'b1010101010, 10, 4, 0));
    check("t1_busy",  128'(nbusy), 128'(40));
    check("t1_done_at", 128'(done_first), 128'(40));
    check("t1_ndone", 128'(ndone), 128'(1));

    // 7E1 div=3, 0x41
    run(1, 8'h41, 8'h41, 16'd3, -1, 16'd0, 0, 33);
    check("t2_wave",  cap, wave(16'b1010000010, 10, 3, 0));
    check("t2_busy",  128'(nbusy), 128'(30));
    check("t2_done_at", 128'(done_first), 128'(30));

    // 8O2 div=2, 0xFF
    run(2, 8'hFF, 8'hFF, 16'd2, -1, 16'd0, 0, 27);
    check("t3_wave",  cap, wave(16'b111111111110, 12, 2, 0));
    check("t3_busy",  128'(nbusy), 128'(24));
    check("t3_done_at", 128'(done_first), 128'(24));

    // 8N1 div=5 back-to-back 0xA0 then 0x0F with s_valid held
    run(0, 8'hA0, 8'h0F, 16'd5, -1, 16'd0, 51, 104);
    check("t4_wave", cap, wave(16'b1101000000, 10, 5, 0) & wave(16'b1000011110, 10, 5, 51));
    check("t4_ndone", 128'(ndone), 128'(2));
    check("t4_done1", 128'(done_first), 128'(50));
    check("t4_done2", 128'(done_last), 128'(101));
    check("t4_busy",  128'(nbusy), 128'(100));

    // div=0 clamps to one clock per bit; s_data change after accept ignored
    run(0, 8'h3C, 8'hFF, 16'd0, -1, 16'd0, 0, 13);
    check("t5a_wave", cap, wave(16'b1001111000, 10, 1, 0));
    check("t5a_done_at", 128'(done_first), 128'(10));

    run(0, 8'hC3, 8'h00, 16'd1, -1, 16'd0, 0, 13);
    check("t5b_wave", cap, wave(16'b1110000110, 10, 1, 0));
    check("t5b_ndone", 128'(ndone), 128'(1));

    // div changed to 9 mid-frame
    run(0, 8'h96, 8'h96, 16'd2, 3, 16'd9, 0, 23);
    check("t5c_wave", cap, wave(16'b1100101100, 10, 2, 0));
    check("t5c_done_at", 128'(done_first), 128'(20));

    // Reset in the middle of the data bits
    @(negedge clk);
    s_valid[0] = 1'b1;
    d0 = 8'h00;
    dv[0] = 16'd4;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      s_valid[0] = 1'b0;
    end
    check("t6_pre_txd",  128'(txd[0]),  128'(0));
    check("t6_pre_busy", 128'(busy[0]), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("t6_async_txd",   128'(txd[0]),     128'(1));
    check("t6_async_busy",  128'(busy[0]),    128'(0));
    check("t6_async_ready", 128'(s_ready[0]), 128'(0));
    check("t6_async_done",  128'(done[0]),    128'(0));
    ndone = 0;
    repeat (2) begin
      @(negedge clk);
      ndone += int'(done[0]);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      ndone += int'(done[0]);
    end
    check("t6_no_done_abort", 128'(ndone), 128'(0));
    check("t6_idle_txd", 128'(txd[0]), 128'(1));
    run(0, 8'h55, 8'h55, 16'd4, -1, 16'd0, 0, 43);
    check("t6_wave", cap, wave(16'b1010101010, 10, 4, 0));
    check("t6_ndone", 128'(ndone), 128'(1));
    check("t6_done_at", 128'(done_first), 128'(40));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
